instr_fetch_unit: RTL and testbench

- Front end of the CPU pipeline; sits directly upstream of the opcode decoder/control unit.
- Maintains the PC and issues one-at-a-time read requests to instruction memory.
- Buffers returned words in a small FIFO and presents {pc, opcode, operand} to decode over a valid/ready handshake.
- Accepts branch redirects from downstream and drops stale fetched or in-flight instructions.

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch front end.
//   fetch_state_t : request FSM states (REQ, WAIT, DISCARD)
//   fetch_entry_t : default-width prefetch entry {addr, instr}
//   opcode_of / operand_of : field extraction from an instruction word of
//                            run-time width, zero-extended to MAX_INSTR_W
package fetch_pkg;

  localparam int OPCODE_W    = 8;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 16;
  localparam int MAX_INSTR_W = 64;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  addr;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Opcode lives in the top OPCODE_W bits of an instr_w-bit word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [MAX_INSTR_W-1:0] word,
                                                    input int instr_w);
    return OPCODE_W'(word >> (instr_w - OPCODE_W));
  endfunction

  // Operand is everything below the opcode.
  function automatic logic [MAX_INSTR_W-1:0] operand_of(input logic [MAX_INSTR_W-1:0] word,
                                                       input int instr_w);
    return word & ((MAX_INSTR_W'(1) << (instr_w - OPCODE_W)) - MAX_INSTR_W'(1));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding prefetched instruction entries.
//   clk, rst       : clock, synchronous active-high reset
//   push/push_data : write an entry
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the FIFO; wins over push and pop
//   head           : current head entry (valid when !empty)
//   count/full/empty : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: pipeline front end. Keeps the PC, issues one outstanding
// read at a time to instruction memory, buffers returned words with their
// fetch address and hands {pc, opcode, operand} to decode over valid/ready.
// Branch redirects flush the buffer and drop any stale in-flight word.
//   clk, rst                      : clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt   : request channel (transfer on req && gnt)
//   imem_rvalid/imem_rdata        : response channel
//   dec_valid/dec_ready           : decode handshake
//   dec_opcode/dec_operand/dec_pc : presented instruction (zero when !dec_valid)
//   br_taken/br_target            : redirect from branch resolution
// Build option FETCH_BYPASS_EN: a word returning into an empty buffer is
// presented to decode in the same cycle, and is only buffered if decode
// does not take it.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter int          INSTR_W    = 16,
  parameter int          FIFO_DEPTH = 2,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [7:0]         dec_opcode,
  output logic [INSTR_W-9:0] dec_operand,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target
);

  localparam int OPND_W = INSTR_W - OPCODE_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] inflight_addr_reg;

  logic              fifo_push;
  logic              fifo_pop;
  entry_t            fifo_wdata;
  entry_t            fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  logic              grant;
  logic              word_keep;
  logic              out_valid;
  entry_t            out_entry;

  // Only REQ has nothing outstanding, so the room check reduces to count.
  assign imem_req  = !rst && (state_reg == REQ) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign imem_addr = pc_reg;
  assign grant     = imem_req && imem_gnt;

  // A returning word is wanted only if we are waiting for it and no redirect
  // is invalidating it this very cycle.
  assign word_keep  = (state_reg == WAIT) && imem_rvalid && !br_taken;
  assign fifo_wdata = '{addr: inflight_addr_reg, instr: imem_rdata};
  assign fifo_pop   = !fifo_empty && dec_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = word_keep && fifo_empty;
  assign out_valid  = !fifo_empty || bypass_hit;
  assign out_entry  = bypass_hit ? fifo_wdata : fifo_head;
  assign fifo_push  = word_keep && !(bypass_hit && dec_ready);
`else
  assign out_valid  = !fifo_empty;
  assign out_entry  = fifo_head;
  assign fifo_push  = word_keep;
`endif

  assign dec_valid   = !rst && out_valid;
  assign dec_pc      = dec_valid ? out_entry.addr : '0;
  assign dec_opcode  = dec_valid ? opcode_of(MAX_INSTR_W'(out_entry.instr), INSTR_W) : '0;
  assign dec_operand = dec_valid ?
                       OPND_W'(operand_of(MAX_INSTR_W'(out_entry.instr), INSTR_W)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= REQ;
      pc_reg            <= ADDR_W'(RESET_PC);
      inflight_addr_reg <= '0;
    end else if (br_taken) begin
      pc_reg <= br_target;
      case (state_reg)
        // A grant coinciding with the redirect fetched from the old stream.
        REQ:     state_reg <= grant ? DISCARD : REQ;
        // In WAIT/DISCARD a response this cycle retires the outstanding read.
        default: state_reg <= imem_rvalid ? REQ : DISCARD;
      endcase
    end else begin
      case (state_reg)
        REQ: begin
          if (grant) begin
            inflight_addr_reg <= pc_reg;
            pc_reg            <= pc_reg + 1'b1;
            state_reg         <= WAIT;
          end
        end
        WAIT:    if (imem_rvalid) state_reg <= REQ;
        DISCARD: if (imem_rvalid) state_reg <= REQ;
        default: state_reg <= REQ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .flush     (br_taken),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. A second instance with RESET_PC=0xFE
// runs alongside for the PC wrap scenario. Memory answers every grant two
// cycles later with word {addr ^ 8'h5A, addr}.
module tb_instr_fetch_unit;

  localparam int LAT = 2;
`ifdef FETCH_BYPASS_EN
  localparam int LAT_EXP = 0;
`else
  localparam int LAT_EXP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_gnt, imem_rvalid, dec_ready, br_taken;
  logic [7:0]  br_target, imem_addr, dec_opcode, dec_operand, dec_pc;
  logic [15:0] imem_rdata;
  logic        imem_req, dec_valid;

  logic        req2, rvalid2, dvalid2;
  logic [7:0]  addr2, op2, opnd2, pc2;
  logic [15:0] rdata2;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_operand(dec_operand), .dec_pc(dec_pc), .br_taken(br_taken),
    .br_target(br_target)
  );

  instr_fetch_unit #(.RESET_PC(32'hFE)) dut_fe (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(1'b1), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .dec_valid(dvalid2), .dec_ready(1'b1), .dec_opcode(op2),
    .dec_operand(opnd2), .dec_pc(pc2), .br_taken(1'b0),
    .br_target(8'h00)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int busy [2];
  int dly  [2];
  logic [7:0] maddr [2];

  int req_q[$], pop_pc_q[$], pop_op_q[$], pop_opnd_q[$], rv_cyc_q[$], pop_cyc_q[$];
  int req2_q[$], pop2_pc_q[$], pop2_op_q[$], pop2_opnd_q[$];

  logic       s_req, s_dvalid, s_rvalid;
  logic [7:0] s_addr, s_dpc, s_dop, s_dopnd;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // One clock cycle: called at a falling edge with inputs already set.
  task automatic tick();
    imem_rvalid = 1'b0;
    rvalid2     = 1'b0;
    if (rst) begin
      busy[0] = 0;
      busy[1] = 0;
    end else begin
      if (busy[0] != 0) begin
        if (dly[0] == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_word(maddr[0]); busy[0] = 0;
        end else dly[0]--;
      end
      if (busy[1] != 0) begin
        if (dly[1] == 0) begin
          rvalid2 = 1'b1; rdata2 = mem_word(maddr[1]); busy[1] = 0;
        end else dly[1]--;
      end
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_dvalid = dec_valid; s_dpc = dec_pc;
    s_dop = dec_opcode; s_dopnd = dec_operand; s_rvalid = imem_rvalid;
    if (imem_rvalid) rv_cyc_q.push_back(cyc);
    if (imem_req && imem_gnt) begin
      req_q.push_back(int'(imem_addr));
      busy[0] = 1; dly[0] = LAT - 1; maddr[0] = imem_addr;
    end
    if (dec_valid && dec_ready) begin
      pop_pc_q.push_back(int'(dec_pc));
      pop_op_q.push_back(int'(dec_opcode));
      pop_opnd_q.push_back(int'(dec_operand));
      pop_cyc_q.push_back(cyc);
      $display("cyc %0d: decode takes pc=%02h opcode=%02h operand=%02h",
               cyc, dec_pc, dec_opcode, dec_operand);
    end
    if (req2) begin
      req2_q.push_back(int'(addr2));
      busy[1] = 1; dly[1] = LAT - 1; maddr[1] = addr2;
    end
    if (dvalid2) begin
      pop2_pc_q.push_back(int'(pc2));
      pop2_op_q.push_back(int'(op2));
      pop2_opnd_q.push_back(int'(opnd2));
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    req_q.delete(); pop_pc_q.delete(); pop_op_q.delete(); pop_opnd_q.delete();
    rv_cyc_q.delete(); pop_cyc_q.delete();
    req2_q.delete(); pop2_pc_q.delete(); pop2_op_q.delete(); pop2_opnd_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; dec_ready = 1'b1; br_taken = 1'b0; br_target = 8'h00; imem_gnt = 1'b1;
    tick();
    tick();
    clear_logs();
    cyc = 0;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int exp_op [4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};
    do_reset();
    repeat (14) tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (qat(req_q, i) !== i) begin
        bad++; $display("FAIL stream_req[%0d]: got %0d expected %0d", i, qat(req_q, i), i);
      end
      total++;
      if (qat(pop_pc_q, i) !== i) begin
        bad++; $display("FAIL stream_pc[%0d]: got %0d expected %0d", i, qat(pop_pc_q, i), i);
      end
      total++;
      if (qat(pop_op_q, i) !== exp_op[i]) begin
        bad++; $display("FAIL stream_op[%0d]: got %0h expected %0h", i, qat(pop_op_q, i), exp_op[i]);
      end
    end
    total++;
    if (qat(pop_opnd_q, 3) !== 3) begin
      bad++; $display("FAIL stream_operand: got %0d expected 3", qat(pop_opnd_q, 3));
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (qat(pop_cyc_q, i) - qat(rv_cyc_q, i) !== LAT_EXP) begin
        bad++; $display("FAIL stream_latency[%0d]: got %0d expected %0d", i,
                        qat(pop_cyc_q, i) - qat(rv_cyc_q, i), LAT_EXP);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dec_ready = 1'b0;
    repeat (10) tick();
    total++;
    if (req_q.size() !== 2) begin
      bad++; $display("FAIL bp_req_count: got %0d expected 2", req_q.size());
    end
    total++;
    if (s_req !== 1'b0) begin
      bad++; $display("FAIL bp_req_stalled: got %0b expected 0", s_req);
    end
    total++;
    if (s_dvalid !== 1'b1 || s_dpc !== 8'h00) begin
      bad++; $display("FAIL bp_head: got valid=%0b pc=%0h expected valid=1 pc=0", s_dvalid, s_dpc);
    end
    dec_ready = 1'b1;
    repeat (8) tick();
    total++;
    if (qat(pop_cyc_q, 0) !== 10) begin
      bad++; $display("FAIL bp_first_pop_cycle: got %0d expected 10", qat(pop_cyc_q, 0));
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (qat(pop_pc_q, i) !== i) begin
        bad++; $display("FAIL bp_pop_pc[%0d]: got %0d expected %0d", i, qat(pop_pc_q, i), i);
      end
    end
    total++;
    if (qat(req_q, 2) !== 2) begin
      bad++; $display("FAIL bp_resume_addr: got %0d expected 2", qat(req_q, 2));
    end
  endtask

  task automatic test_redirect();
    bit found = 0;
    do_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (s_req && s_addr == 8'h05) found = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL redirect_wait_addr5: got timeout expected grant of addr 5");
      return;
    end
    br_taken = 1'b1; br_target = 8'h40;
    tick();
    br_taken = 1'b0;
    tick();
    total++;
    if (s_dvalid !== 1'b0) begin
      bad++; $display("FAIL redirect_valid_after: got %0b expected 0", s_dvalid);
    end
    repeat (8) tick();
    total++;
    if (qat(req_q, 6) !== 'h40) begin
      bad++; $display("FAIL redirect_next_req: got %0h expected 40", qat(req_q, 6));
    end
    total++;
    if (qat(pop_pc_q, 5) !== 'h40) begin
      bad++; $display("FAIL redirect_first_pc: got %0h expected 40", qat(pop_pc_q, 5));
    end
    total++;
    if (qat(pop_op_q, 5) !== 'h1A) begin
      bad++; $display("FAIL redirect_first_op: got %0h expected 1a", qat(pop_op_q, 5));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++;
    if (s_req !== 1'b0) begin
      bad++; $display("FAIL reset_req: got %0b expected 0", s_req);
    end
    total++;
    if (s_dvalid !== 1'b0) begin
      bad++; $display("FAIL reset_dec_valid: got %0b expected 0", s_dvalid);
    end
    total++;
    if ({s_dpc, s_dop, s_dopnd} !== 24'h0) begin
      bad++; $display("FAIL reset_dec_fields: got pc=%0h op=%0h opnd=%0h expected 0 0 0",
                      s_dpc, s_dop, s_dopnd);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (s_req !== 1'b1 || s_addr !== 8'h00) begin
      bad++; $display("FAIL reset_first_req: got req=%0b addr=%0h expected req=1 addr=0", s_req, s_addr);
    end
    total++;
    if (s_dvalid !== 1'b0) begin
      bad++; $display("FAIL reset_empty_after: got %0b expected 0", s_dvalid);
    end
  endtask

  task automatic test_br_rvalid_pop();
    do_reset();
    dec_ready = 1'b0;
    repeat (5) tick();
    dec_ready = 1'b1; br_taken = 1'b1; br_target = 8'h20;
    tick();
    br_taken = 1'b0;
    total++;
    if (s_rvalid !== 1'b1 || s_dvalid !== 1'b1) begin
      bad++; $display("FAIL brpop_setup: got rvalid=%0b valid=%0b expected 1 1", s_rvalid, s_dvalid);
    end
    total++;
    if (s_dpc !== 8'h00 || s_dop !== 8'h5A) begin
      bad++; $display("FAIL brpop_consumed: got pc=%0h op=%0h expected pc=0 op=5a", s_dpc, s_dop);
    end
    tick();
    total++;
    if (s_dvalid !== 1'b0) begin
      bad++; $display("FAIL brpop_empty_next: got %0b expected 0", s_dvalid);
    end
    total++;
    if (s_req !== 1'b1 || s_addr !== 8'h20) begin
      bad++; $display("FAIL brpop_target_req: got req=%0b addr=%0h expected req=1 addr=20", s_req, s_addr);
    end
    repeat (6) tick();
    total++;
    if (qat(pop_pc_q, 1) !== 'h20) begin
      bad++; $display("FAIL brpop_next_pc: got %0h expected 20", qat(pop_pc_q, 1));
    end
  endtask

  task automatic test_pc_wrap();
    int exp_addr [4] = '{'hFE, 'hFF, 'h00, 'h01};
    do_reset();
    repeat (14) tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (qat(req2_q, i) !== exp_addr[i]) begin
        bad++; $display("FAIL wrap_req[%0d]: got %0h expected %0h", i, qat(req2_q, i), exp_addr[i]);
      end
    end
    total++;
    if (qat(pop2_pc_q, 1) !== 'hFF || qat(pop2_op_q, 1) !== 'hA5 || qat(pop2_opnd_q, 1) !== 'hFF) begin
      bad++; $display("FAIL wrap_pop: got pc=%0h op=%0h opnd=%0h expected ff a5 ff",
                      qat(pop2_pc_q, 1), qat(pop2_op_q, 1), qat(pop2_opnd_q, 1));
    end
    total++;
    if (qat(pop2_pc_q, 2) !== 'h00) begin
      bad++; $display("FAIL wrap_pop_zero: got %0h expected 0", qat(pop2_pc_q, 2));
    end
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    rvalid2 = 1'b0; rdata2 = '0; dec_ready = 1'b1; br_taken = 1'b0; br_target = '0;
    @(negedge clk);
    test_stream();
    test_backpressure();
    test_redirect();
    test_reset();
    test_br_rvalid_pop();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
